uart_tx_arbitro: RTL
====================

# uart_tx_arbitro

Round-robin scheduler that shares one UART_2 transmitter among N_REQ byte requesters. It grants one requester at a time and latches that requester's byte. It then sequences the UART_2 `IDLE_UART2` and `data_in2` inputs through exactly one 11-bit frame (start, 8 data LSB-first, even parity, stop) and forces a guard gap before the next frame. The block sits between the byte-producing clients and UART_2, and is the only driver of UART_2's transmit-side inputs.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `FRAME_CYCLES`, default 12: cycles `IDLE_UART` is held low per frame, minimum 12 (1 preparation + start + 8 data + parity + stop).
- `GAP_CYCLES`, default 2: cycles `IDLE_UART` is held high between frames, minimum 1.
- `UART_CLK`  in  1  single clock; the same clock as UART_2.
- `RESET`  in  1  synchronous, active-high reset.
- `REQ`  in  N_REQ  per-requester transmit request, level.
- `DATA_REQ`  in  8*N_REQ  byte i occupies bits [8i+7:8i].
- `GRANT`  out  N_REQ  one-hot, 1-cycle pulse when a request is accepted.
- `DONE`  out  N_REQ  one-hot, 1-cycle pulse on the owner's last frame cycle.
- `BUSY`  out  1  high in ENVIO and PAUSA.
- `OWNER`  out  clog2(N_REQ)  index of the current or last granted requester.
- `IDLE_UART`  out  1  drives UART_2 `IDLE_UART2`.
- `DATA_UART`  out  8  drives UART_2 `data_in2`.

## Operation
- States: REPOSO, ENVIO, PAUSA.
- REPOSO: `IDLE_UART`=1.
  - If any `REQ` bit is set, select the winner round-robin, starting from `ptr`.
  - On a win: latch `DATA_REQ` of the winner into `DATA_UART`, set `OWNER`, pulse `GRANT[winner]`, set `ptr`=(winner+1) mod N_REQ, and go to ENVIO.
- ENVIO: `IDLE_UART`=0 for FRAME_CYCLES cycles, counted by `cnt`.
  - `DATA_UART` is frozen for the whole frame. UART_2 samples `data_in2` live and restarts a frame if it changes, so it must not change.
  - On the last cycle: pulse `DONE[OWNER]` and go to PAUSA.
- PAUSA: `IDLE_UART`=1 for GAP_CYCLES cycles. This resets UART_2 counters and holds its line high.
  - On the last PAUSA cycle, arbitrate exactly as in REPOSO.
  - With a winner, go directly to ENVIO. With no request, go to REPOSO.
- Request rules:
  - A requester holds `REQ` and `DATA_REQ` stable until it sees `GRANT`.
  - A `REQ` dropped before `GRANT` is a withdrawn request, with no side effects.
  - `REQ` still high after `GRANT` is a new request, but it loses priority to the others.
- Arbitration never happens in ENVIO. `REQ` changes during ENVIO are ignored until arbitration.
- `cnt` has width clog2(max(FRAME_CYCLES, GAP_CYCLES))+1. It resets to 0 on every state entry. There is no wrap inside a state.
- Reset values: state=REPOSO, `IDLE_UART`=1, `DATA_UART`=0, `GRANT`=0, `DONE`=0, `BUSY`=0, `OWNER`=0, `ptr`=0 (requester 0 has first priority), `cnt`=0.
- `RESET` mid-frame aborts the frame. No `DONE` is issued, and `IDLE_UART`=1 from the next edge.
- Simultaneous `RESET` and `REQ`: reset wins, and there is no `GRANT`.

## Timing
- All outputs are registered.
- `REQ` is sampled at edge t in REPOSO. `GRANT`, `IDLE_UART`=0 and the new `DATA_UART` all appear after edge t+1.
- `IDLE_UART` stays low for cycles t+1 .. t+FRAME_CYCLES.
- UART_2 drives the start bit in frame cycle 2, data in cycles 3-10, parity in cycle 11 and stop in cycle 12.
- `DONE` is high in cycle t+FRAME_CYCLES.
- Back-to-back frame period is exactly FRAME_CYCLES+GAP_CYCLES cycles.
- Latency from an idle-state request to the first frame cycle is 1 cycle.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding REPOSO=0, ENVIO=1, PAUSA=2;
  - `UART_FRAME_MIN`=12;
  - `UART_BITS_FRAME`=11.
- UART_2 and its receiver checker use the same package.
- One sub-module, `arbitro_rr`: combinational round-robin priority encoder.
  - Inputs: `REQ`, `ptr`.
  - Outputs: `valid`, `winner`.
- The controller FSM, counter and data latch stay in `uart_tx_arbitro`.

## Test plan
- Single request: `REQ`=0001, `DATA_REQ[7:0]`=8'hA5 → `GRANT`=0001 next cycle and `IDLE_UART` low for 12 cycles. UART_2 TX serial stream is 0,1,0,1,0,0,1,0,1,0,1 (start, data A5 LSB-first, parity 0, stop). `DONE`=0001 in frame cycle 12.
- All four requesting continuously, bytes 8'h01/02/03/04 → grants in order 0,1,2,3,0. Period between grants is 14 cycles. `OWNER` tracks each grant.
- Fairness: `REQ`=0101 held → grants alternate 0,2,0,2. Requester 1 is raised mid-frame of requester 0, so the next grant order is 1 then 2.
- Data stability: change `DATA_REQ[7:0]` from 8'h3C to 8'hFF during ENVIO → `DATA_UART` stays 8'h3C for all 12 cycles, and the serial stream matches 3C with parity 0.
- `RESET` asserted in frame cycle 6 → `IDLE_UART`=1, `BUSY`=0, no `DONE` pulse. The next `REQ`=0010 is granted from `ptr`=0 as requester 1.
- Withdrawn request: `REQ[3]` pulses high only during PAUSA except its last cycle → no `GRANT`, and the FSM returns to REPOSO.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for UART_2, its transmit scheduler and the receiver checker.
package uart_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ENVIO  = 2'd1,
    PAUSA  = 2'd2
  } uart_state_e;

  localparam int unsigned UART_FRAME_MIN  = 12;
  localparam int unsigned UART_BITS_FRAME = 11;

  // One spare bit so the counter never wraps before the terminal compare.
  function automatic int unsigned uart_cnt_width(input int unsigned frame_cycles,
                                                 input int unsigned gap_cycles);
    int unsigned longest;
    longest = (frame_cycles > gap_cycles) ? frame_cycles : gap_cycles;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin priority encoder: first set request at or after ptr wins.
module arbitro_rr
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         REQ,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] winner
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  always_comb begin
    logic [PTR_W-1:0] idx;
    int unsigned      sum;
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    sum    = 0;
    // Modulo keeps the scan correct when N_REQ is not a power of two.
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = 32'(ptr) + k;
      idx = PTR_W'(sum % N_REQ);
      if (!valid && REQ[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbitro.sv
// Shares one UART_2 transmitter among N_REQ byte requesters: grant, one frame, guard gap.
module uart_tx_arbitro
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned FRAME_CYCLES = 12,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic                     UART_CLK,
  input  logic                     RESET,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [8*N_REQ-1:0]       DATA_REQ,
  output logic [N_REQ-1:0]         GRANT,
  output logic [N_REQ-1:0]         DONE,
  output logic                     BUSY,
  output logic [$clog2(N_REQ)-1:0] OWNER,
  output logic                     IDLE_UART,
  output logic [7:0]               DATA_UART
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = uart_cnt_width(FRAME_CYCLES, GAP_CYCLES);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] DONE_AT    = CNT_W'(FRAME_CYCLES - 2);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0   = N_REQ'(1);
  localparam logic [PTR_W-1:0] LAST_REQ   = PTR_W'(N_REQ - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_d;
  logic [7:0]       data_d;
  logic [N_REQ-1:0] grant_d, done_d;

  logic             rr_valid;
  logic [PTR_W-1:0] rr_winner;
  logic [7:0]       win_byte;
  logic             arb_en;

  arbitro_rr #(
    .N_REQ (N_REQ)
  ) u_rr (
    .REQ    (REQ),
    .ptr    (ptr_q),
    .valid  (rr_valid),
    .winner (rr_winner)
  );

  always_comb begin
    win_byte = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rr_winner == PTR_W'(i)) begin
        win_byte = DATA_REQ[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    ptr_d   = ptr_q;
    owner_d = OWNER;
    data_d  = DATA_UART;
    grant_d = '0;
    done_d  = '0;
    arb_en  = 1'b0;

    case (state_q)
      REPOSO: begin
        cnt_d  = '0;
        arb_en = 1'b1;
      end
      ENVIO: begin
        // DONE is registered, so it is launched one cycle before the last frame cycle.
        if (cnt_q == DONE_AT) begin
          done_d = ONE_HOT0 << OWNER;
        end
        if (cnt_q == FRAME_LAST) begin
          state_d = PAUSA;
          cnt_d   = '0;
        end
      end
      PAUSA: begin
        if (cnt_q == GAP_LAST) begin
          arb_en  = 1'b1;
          state_d = REPOSO;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = REPOSO;
        cnt_d   = '0;
      end
    endcase

    if (arb_en && rr_valid) begin
      state_d = ENVIO;
      cnt_d   = '0;
      data_d  = win_byte;
      owner_d = rr_winner;
      grant_d = ONE_HOT0 << rr_winner;
      ptr_d   = (rr_winner == LAST_REQ) ? '0 : rr_winner + PTR_W'(1);
    end
  end

  // IDLE_UART and BUSY are registered from the next state so they align with GRANT.
  always_ff @(posedge UART_CLK) begin
    if (RESET) begin
      state_q   <= REPOSO;
      cnt_q     <= '0;
      ptr_q     <= '0;
      OWNER     <= '0;
      DATA_UART <= '0;
      GRANT     <= '0;
      DONE      <= '0;
      BUSY      <= 1'b0;
      IDLE_UART <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      OWNER     <= owner_d;
      DATA_UART <= data_d;
      GRANT     <= grant_d;
      DONE      <= done_d;
      BUSY      <= (state_d != REPOSO);
      IDLE_UART <= (state_d != ENVIO);
    end
  end

endmodule
